rx_pkt_player: RTL and testbench

Parametrised successor to the 2K x 64 RX packet-generation RAM in the PHY emulator. Test firmware loads packet words into an internal dual-port buffer and queues packet descriptors (start address, byte length). A playback FSM then streams each packet as a framed word stream (valid/ready, sop/eop, byte-modulus) toward the MAC RX path, with a programmable inter-packet gap.

---
 rtl/rx_pkt_player.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_rx_pkt_player.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_pkt_player.sv
// -----------------------------------------------------------------------------
// rx_pkt_player
//   Packet playback engine for the PHY emulator RX path. Firmware fills an
//   internal dual-port word buffer and queues packet descriptors
//   (start word address, byte length). An FSM replays each descriptor as a
//   framed valid/ready word stream (sop/eop/mod) with a programmable
//   inter-packet gap.
//
//   Optional build macro: RX_PKT_LOOP_EN
//     When defined, adds input `loop`. While loop = 1, each LOAD reads the
//     descriptor at a play pointer instead of popping it, cycling over the
//     queued list. Clearing loop resumes popping at the play pointer.
//
// Ports
//   clock, reset_n          : clock (rising edge), async active-low reset
//   enable                  : allow new packets; 0 lets the current one finish
//   ipg[7:0]                : idle cycles inserted after each eop
//   wr_data/wr_addr/wr_en   : buffer write port
//   desc_addr/desc_len/
//   desc_push               : descriptor enqueue
//   desc_full/desc_count    : descriptor FIFO status
//   desc_ovf                : sticky, push while full or push with len 0
//   pkt_data/pkt_valid/
//   pkt_ready/pkt_sop/
//   pkt_eop/pkt_mod         : output stream, byte 0 in bits [7:0]
//   busy                    : FSM not idle
//   pkt_sent_cnt[31:0]      : packets completed (wrapping)
//   loop (RX_PKT_LOOP_EN)   : replay queued descriptors indefinitely
// -----------------------------------------------------------------------------
module rx_pkt_player #(
  parameter int unsigned DATAWIDTH  = 64,
  parameter int unsigned ADDRWIDTH  = 11,
  parameter int unsigned ADDRDEPTH  = 2048,
  parameter int unsigned DESC_DEPTH = 16,
  parameter int unsigned LENWIDTH   = 16,
  parameter int unsigned MODWIDTH   = 3
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [7:0]                    ipg,
  input  logic [DATAWIDTH-1:0]          wr_data,
  input  logic [ADDRWIDTH-1:0]          wr_addr,
  input  logic                          wr_en,
  input  logic [ADDRWIDTH-1:0]          desc_addr,
  input  logic [LENWIDTH-1:0]           desc_len,
  input  logic                          desc_push,
`ifdef RX_PKT_LOOP_EN
  input  logic                          loop,
`endif
  output logic                          desc_full,
  output logic [$clog2(DESC_DEPTH):0]   desc_count,
  output logic                          desc_ovf,
  output logic [DATAWIDTH-1:0]          pkt_data,
  output logic                          pkt_valid,
  input  logic                          pkt_ready,
  output logic                          pkt_sop,
  output logic                          pkt_eop,
  output logic [MODWIDTH-1:0]           pkt_mod,
  output logic                          busy,
  output logic [31:0]                   pkt_sent_cnt
);

  localparam int unsigned BYTES = DATAWIDTH / 8;
  localparam int unsigned PW    = $clog2(DESC_DEPTH);
  localparam int unsigned CW    = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // ---------------------------------------------------------------------------
  // Packet buffer (write port and registered read live in separate blocks)
  // ---------------------------------------------------------------------------
  logic [DATAWIDTH-1:0] r_mem [ADDRDEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Descriptor FIFO
  // ---------------------------------------------------------------------------
  logic [ADDRWIDTH-1:0] r_dq_addr [DESC_DEPTH];
  logic [LENWIDTH-1:0]  r_dq_len  [DESC_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;

  logic                 w_full;
  logic                 w_push_ok;
  logic                 w_push_bad;
  logic                 w_loop;
  logic                 w_do_pop;
  logic [PW-1:0]        w_play_off;
  logic [PW-1:0]        w_head_ptr;
  logic [CW-1:0]        w_pop_n;
  logic [ADDRWIDTH-1:0] w_head_addr;
  logic [LENWIDTH-1:0]  w_head_len;
  logic [LENWIDTH:0]    w_len_ext;
  logic [LENWIDTH-1:0]  w_head_words;

  assign w_full     = (r_count == CW'(DESC_DEPTH));
  assign w_push_ok  = desc_push && !w_full && (desc_len != '0);
  assign w_push_bad = desc_push && !w_push_ok;

`ifdef RX_PKT_LOOP_EN
  logic [PW-1:0] r_play_off;

  // Play pointer kept as an offset from the FIFO head so it always lies
  // inside the queued entries; it wraps at the current count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_play_off <= '0;
    end else if (r_state == S_LOAD) begin
      if (loop) begin
        r_play_off <= (({1'b0, r_play_off} + CW'(1)) >= r_count) ? '0
                                                               : r_play_off + PW'(1);
      end else begin
        r_play_off <= '0;
      end
    end
  end

  assign w_loop     = loop;
  assign w_play_off = r_play_off;
`else
  assign w_loop     = 1'b0;
  assign w_play_off = '0;
`endif

  assign w_head_ptr   = r_rd_ptr + w_play_off;
  assign w_head_addr  = r_dq_addr[w_head_ptr];
  assign w_head_len   = r_dq_len[w_head_ptr];
  assign w_len_ext    = {1'b0, w_head_len} + (LENWIDTH + 1)'(BYTES - 1);
  assign w_head_words = LENWIDTH'(w_len_ext >> MODWIDTH);

  // A pop in the middle of the list (after leaving loop mode) drops the
  // entries already played ahead of the play pointer.
  assign w_do_pop = (r_state == S_LOAD) && !w_loop;
  assign w_pop_n  = w_do_pop ? ({1'b0, w_play_off} + CW'(1)) : '0;

  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_dq_addr[r_wr_ptr] <= desc_addr;
      r_dq_len[r_wr_ptr]  <= desc_len;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)   r_rd_ptr <= w_head_ptr + PW'(1);
      r_count <= r_count + CW'(w_push_ok) - w_pop_n;
      if (w_push_bad) r_ovf <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet context and read issue
  // ---------------------------------------------------------------------------
  logic [ADDRWIDTH-1:0] r_base;
  logic [LENWIDTH-1:0]  r_words;
  logic [MODWIDTH-1:0]  r_mod;
  logic [LENWIDTH-1:0]  r_issue_idx;
  logic [7:0]           r_gap;
  logic [31:0]          r_sent;

  logic                 r_out_v;
  logic [DATAWIDTH-1:0] r_out_data;
  logic                 r_out_sop;
  logic                 r_out_eop;
  logic [MODWIDTH-1:0]  r_out_mod;
  logic                 r_skid_v;
  logic [DATAWIDTH-1:0] r_skid_data;
  logic                 r_skid_sop;
  logic                 r_skid_eop;
  logic [MODWIDTH-1:0]  r_skid_mod;

  logic                 w_is_load;
  logic [LENWIDTH-1:0]  w_cur_idx;
  logic [LENWIDTH-1:0]  w_cur_words;
  logic [ADDRWIDTH-1:0] w_cur_base;
  logic [MODWIDTH-1:0]  w_cur_mod;
  logic [ADDRWIDTH-1:0] w_rd_addr;
  logic                 w_iss_sop;
  logic                 w_iss_eop;
  logic [MODWIDTH-1:0]  w_iss_mod;
  logic                 w_issue;
  logic                 w_out_free;
  logic                 w_eop_hs;

  // In LOAD the first read is issued straight from the FIFO head, so the
  // first word reaches the output register on the edge leaving LOAD.
  assign w_is_load   = (r_state == S_LOAD);
  assign w_cur_idx   = w_is_load ? '0           : r_issue_idx;
  assign w_cur_words = w_is_load ? w_head_words : r_words;
  assign w_cur_base  = w_is_load ? w_head_addr  : r_base;
  assign w_cur_mod   = w_is_load ? w_head_len[MODWIDTH-1:0] : r_mod;
  assign w_rd_addr   = w_cur_base + ADDRWIDTH'(w_cur_idx);
  assign w_iss_sop   = (w_cur_idx == '0);
  assign w_iss_eop   = (w_cur_idx == (w_cur_words - LENWIDTH'(1)));
  assign w_iss_mod   = w_iss_eop ? w_cur_mod : '0;

  // Issue depends only on registered state: an empty skid slot always has
  // room for the word read this cycle, even if the sink stalls.
  assign w_issue    = w_is_load ||
                      ((r_state == S_STREAM) && (r_issue_idx < r_words) && !r_skid_v);
  assign w_out_free = !r_out_v || pkt_ready;
  assign w_eop_hs   = (r_state == S_STREAM) && r_out_v && pkt_ready && r_out_eop;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable && (r_count != '0)) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_STREAM;
      S_STREAM: if (w_eop_hs) w_state_nxt = (ipg == 8'd0) ? S_IDLE : S_GAP;
      S_GAP:    if (r_gap == 8'd0) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_words     <= '0;
      r_mod       <= '0;
      r_issue_idx <= '0;
      r_gap       <= '0;
      r_sent      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_is_load) begin
        r_base      <= w_head_addr;
        r_words     <= w_head_words;
        r_mod       <= w_head_len[MODWIDTH-1:0];
        r_issue_idx <= LENWIDTH'(1);
      end else if (w_issue) begin
        r_issue_idx <= r_issue_idx + LENWIDTH'(1);
      end
      if (w_eop_hs) begin
        r_sent <= r_sent + 32'd1;
        r_gap  <= ipg - 8'd1;
      end else if (r_state == S_GAP) begin
        r_gap  <= r_gap - 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register + skid register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_v     <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_mod   <= '0;
      r_skid_v    <= 1'b0;
      r_skid_data <= '0;
      r_skid_sop  <= 1'b0;
      r_skid_eop  <= 1'b0;
      r_skid_mod  <= '0;
    end else if (w_out_free) begin
      if (r_skid_v) begin
        r_out_v    <= 1'b1;
        r_out_data <= r_skid_data;
        r_out_sop  <= r_skid_sop;
        r_out_eop  <= r_skid_eop;
        r_out_mod  <= r_skid_mod;
        r_skid_v   <= 1'b0;
      end else if (w_issue) begin
        r_out_v    <= 1'b1;
        r_out_data <= r_mem[w_rd_addr];
        r_out_sop  <= w_iss_sop;
        r_out_eop  <= w_iss_eop;
        r_out_mod  <= w_iss_mod;
      end else begin
        r_out_v    <= 1'b0;
        r_out_sop  <= 1'b0;
        r_out_eop  <= 1'b0;
        r_out_mod  <= '0;
      end
    end else if (w_issue) begin
      r_skid_v    <= 1'b1;
      r_skid_data <= r_mem[w_rd_addr];
      r_skid_sop  <= w_iss_sop;
      r_skid_eop  <= w_iss_eop;
      r_skid_mod  <= w_iss_mod;
    end
  end

  assign desc_full    = w_full;
  assign desc_count   = r_count;
  assign desc_ovf     = r_ovf;
  assign pkt_data     = r_out_data;
  assign pkt_valid    = r_out_v;
  assign pkt_sop      = r_out_sop;
  assign pkt_eop      = r_out_eop;
  assign pkt_mod      = r_out_mod;
  assign busy         = (r_state != S_IDLE);
  assign pkt_sent_cnt = r_sent;

endmodule

// File: tb/tb_rx_pkt_player.sv
module tb_rx_pkt_player;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  ipg;
  logic [63:0] wr_data;
  logic [10:0] wr_addr;
  logic        wr_en;
  logic [10:0] desc_addr;
  logic [15:0] desc_len;
  logic        desc_push;
  logic        desc_full;
  logic [4:0]  desc_count;
  logic        desc_ovf;
  logic [63:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        pkt_sop;
  logic        pkt_eop;
  logic [2:0]  pkt_mod;
  logic        busy;
  logic [31:0] pkt_sent_cnt;
`ifdef RX_PKT_LOOP_EN
  logic        loop;
`endif

  always #5 clock = ~clock;

  rx_pkt_player #(
    .DATAWIDTH (64),
    .ADDRWIDTH (11),
    .ADDRDEPTH (2048),
    .DESC_DEPTH(16),
    .LENWIDTH  (16),
    .MODWIDTH  (3)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .ipg         (ipg),
    .wr_data     (wr_data),
    .wr_addr     (wr_addr),
    .wr_en       (wr_en),
    .desc_addr   (desc_addr),
    .desc_len    (desc_len),
    .desc_push   (desc_push),
`ifdef RX_PKT_LOOP_EN
    .loop        (loop),
`endif
    .desc_full   (desc_full),
    .desc_count  (desc_count),
    .desc_ovf    (desc_ovf),
    .pkt_data    (pkt_data),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_sop     (pkt_sop),
    .pkt_eop     (pkt_eop),
    .pkt_mod     (pkt_mod),
    .busy        (busy),
    .pkt_sent_cnt(pkt_sent_cnt)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned a;
    int unsigned l;
  } desc_t;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } word_t;

  logic [63:0] mem_m [2048];
  desc_t       dq[$];
  word_t       wq[$];
  int          sop_cyc[$];
  int          eop_cyc[$];
  int          sent_m  = 0;
  logic        ovf_m   = 1'b0;
  logic [2:0]  last_mod;
  int          total   = 0;
  int          bad     = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int unsigned a, input logic [63:0] d);
    wr_addr = 11'(a);
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clock);
    wr_en   = 1'b0;
    mem_m[a % 2048] = d;
  endtask

  task automatic wr_rand(input int unsigned a, input int unsigned nwords);
    for (int unsigned i = 0; i < nwords; i++)
      wr((a + i) % 2048, {$urandom, $urandom});
  endtask

  task automatic push(input int unsigned a, input int unsigned l);
    desc_t d;
    desc_addr = 11'(a);
    desc_len  = 16'(l);
    desc_push = 1'b1;
    @(negedge clock);
    desc_push = 1'b0;
    d.a = a;
    d.l = l;
    if (dq.size() < 16 && l != 0) dq.push_back(d);
    else ovf_m = 1'b1;
  endtask

  // Expand the next queued descriptor into its expected word sequence.
  task automatic expand();
    desc_t d;
    word_t w;
    int unsigned n;
    d = dq.pop_front();
    n = (d.l + 7) / 8;
    for (int unsigned i = 0; i < n; i++) begin
      w.d   = mem_m[(d.a + i) % 2048];
      w.sop = (i == 0);
      w.eop = (i == n - 1);
      w.mod = (i == n - 1) ? 3'(d.l % 8) : 3'd0;
      wq.push_back(w);
    end
  endtask

  // rmode: 0 = ready held high, 1 = ready 1010..., 2 = random ready
  task automatic run(input int n, input int rmode);
    int   done;
    int   cyc;
    logic r;
    logic stall;
    word_t w;
    done  = 0;
    cyc   = 0;
    stall = 1'b0;
    sop_cyc.delete();
    eop_cyc.delete();
    enable = 1'b1;
    while (done < n && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      if (stall) chk("hold_valid", 64'(pkt_valid), 64'd1);
      case (rmode)
        0:       r = 1'b1;
        1:       r = 1'(cyc % 2);
        default: r = 1'($urandom_range(0, 1));
      endcase
      pkt_ready = r;
      if (pkt_valid) begin
        if (wq.size() == 0 && dq.size() != 0) expand();
        if (wq.size() == 0) begin
          chk("extra_word", 64'(pkt_valid), 64'd0);
        end else begin
          w = wq[0];
          chk("data", pkt_data, w.d);
          chk("sop", 64'(pkt_sop), 64'(w.sop));
          chk("eop", 64'(pkt_eop), 64'(w.eop));
          chk("mod", 64'(pkt_mod), 64'(w.mod));
          if (r) begin
            if (w.sop) sop_cyc.push_back(cyc);
            if (w.eop) begin
              eop_cyc.push_back(cyc);
              last_mod = pkt_mod;
              done++;
              sent_m++;
            end
            void'(wq.pop_front());
          end
        end
      end
      stall = pkt_valid && !r;
    end
    if (done < n) chk("run_timeout", 64'(done), 64'(n));
    @(negedge clock);
    enable    = 1'b0;
    pkt_ready = 1'b0;
    chk("sent_cnt", 64'(pkt_sent_cnt), 64'(sent_m));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(pkt_valid), 64'd0);
    chk({tag, "_data"},  pkt_data,        64'd0);
    chk({tag, "_sop"},   64'(pkt_sop),   64'd0);
    chk({tag, "_eop"},   64'(pkt_eop),   64'd0);
    chk({tag, "_mod"},   64'(pkt_mod),   64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_count"}, 64'(desc_count), 64'd0);
    chk({tag, "_full"},  64'(desc_full), 64'd0);
    chk({tag, "_ovf"},   64'(desc_ovf),  64'd0);
    chk({tag, "_sent"},  64'(pkt_sent_cnt), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    check_zero("rst");
    reset_n = 1'b1;
    dq.delete();
    wq.delete();
    sent_m = 0;
    ovf_m  = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    logic [63:0] base;
    int unsigned a;
    int unsigned l;
    int          nw;
    reset_n   = 1'b0;
    enable    = 1'b0;
    ipg       = 8'd0;
    wr_data   = '0;
    wr_addr   = '0;
    wr_en     = 1'b0;
    desc_addr = '0;
    desc_len  = '0;
    desc_push = 1'b0;
    pkt_ready = 1'b0;
`ifdef RX_PKT_LOOP_EN
    loop      = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check_zero("init");
    reset_n = 1'b1;
    @(negedge clock);

    // 60-byte packet from words 0..7
    base = 64'h0706050403020100;
    for (int unsigned i = 0; i < 8; i++) wr(i, base + 64'(i) * 64'h0808080808080808);
    push(0, 60);
    chk("count_one", 64'(desc_count), 64'd1);
    run(1, 0);
    chk("first_lat", 64'(sop_cyc[0]), 64'd2);
    chk("burst8", 64'(eop_cyc[0] - sop_cyc[0]), 64'd7);
    chk("mod60", 64'(last_mod), 64'd4);
    chk("count_empty", 64'(desc_count), 64'd0);

    // Packet wrapping past the top of the buffer
    wr_rand(2046, 2);
    wr(0, {$urandom, $urandom});
    push(2046, 24);
    run(1, 0);
    chk("wrap_len", 64'(eop_cyc[0] - sop_cyc[0]), 64'd2);
    chk("wrap_mod", 64'(last_mod), 64'd0);

    // 16-word packet with ready toggling
    wr_rand(100, 16);
    push(100, 128);
    run(1, 1);

    // Random descriptors under random backpressure
    for (int k = 0; k < 5; k++) begin
      a = $urandom_range(0, 2047);
      l = $urandom_range(1, 96);
      wr_rand(a, (l + 7) / 8);
      push(a, l);
    end
    run(5, 2);
    chk("count_after_rand", 64'(desc_count), 64'(dq.size()));

    // Inter-packet gap
    ipg = 8'd12;
    wr_rand(200, 2);
    push(200, $urandom_range(1, 8));
    push(201, $urandom_range(1, 8));
    run(2, 0);
    chk("ipg12_gap", 64'(sop_cyc[1] - eop_cyc[0]), 64'd15);
    ipg = 8'd0;
    push(200, $urandom_range(1, 8));
    push(201, $urandom_range(1, 8));
    run(2, 0);
    chk("ipg0_gap", 64'(sop_cyc[1] - eop_cyc[0]), 64'd3);

    // Descriptor overflow
    for (int unsigned k = 0; k < 17; k++) push(k, 8);
    chk("full", 64'(desc_full), 64'd1);
    chk("ovf17", 64'(desc_ovf), 64'(ovf_m));
    chk("count16", 64'(desc_count), 64'(dq.size()));
    do_reset();
    push(0, 0);
    chk("ovf_len0", 64'(desc_ovf), 64'(ovf_m));
    chk("count_len0", 64'(desc_count), 64'd0);
    do_reset();

    // Reset while the third word is on the bus
    push(100, 128);
    push(0, 60);
    enable    = 1'b1;
    pkt_ready = 1'b1;
    nw = 0;
    for (int c = 0; c < 50 && nw < 3; c++) begin
      @(negedge clock);
      if (pkt_valid) nw++;
    end
    chk("abort_reach", 64'(nw), 64'd3);
    reset_n = 1'b0;
    #1;
    check_zero("abort");
    @(negedge clock);
    enable    = 1'b0;
    pkt_ready = 1'b0;
    reset_n   = 1'b1;
    dq.delete();
    wq.delete();
    sent_m = 0;
    @(negedge clock);

`ifdef RX_PKT_LOOP_EN
    // Looped replay: A, B, A, B
    ipg = 8'd3;
    wr_rand(300, 2);
    wr_rand(400, 1);
    push(300, 16);
    push(400, 8);
    loop = 1'b1;
    dq.push_back(dq[0]);
    dq.push_back(dq[1]);
    run(4, 0);
    chk("loop_count", 64'(desc_count), 64'd2);
    loop = 1'b0;
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
